// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: datapath widths, default reset PC,
// next-PC source encoding and the J-type target helper.
package pc_pkg;

   localparam int ADDR_W = 32;
   localparam int JIDX_W = 26;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      SRC_SEQ,
      SRC_BRANCH,
      SRC_JUMP,
      SRC_RETURN
   } pc_src_e;

   // J-type target is a concatenation with the PC+4 region bits, never a sum.
   function automatic logic [ADDR_W-1:0] jump_target(input logic [ADDR_W-1:0] seq_pc,
                                                      input logic [JIDX_W-1:0] index);
      return {seq_pc[ADDR_W-1:ADDR_W-4], index, 2'b00};
   endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: push/pop with a wrapping top pointer and
// overwrite-oldest on full. DEPTH must be a power of two, at least 2.
module return_addr_stack
   import pc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ADDR_W
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         top,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] top_ptr;

   // NOTE: the storage array has no reset; count qualifies every entry, so a
   // reset here would only cost flops without changing behaviour.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         // When full, wr_ptr already addresses the oldest entry.
         wr_ptr <= wr_ptr + 1'b1;
         if (count != CNT_W'(DEPTH)) begin
            count <= count + 1'b1;
         end
      end else if (pop && (count != '0)) begin
         wr_ptr <= wr_ptr - 1'b1;
         count  <= count - 1'b1;
      end
   end

   assign top_ptr = wr_ptr - 1'b1;
   assign top     = mem[top_ptr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: arbitrates branch/jump/return redirects into the next
// fetch address. Optional return-address stack checker under PC_SEQ_RAS_EN.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int                RAS_DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         stall,
   input  logic                         branch_valid,
   input  logic [ADDR_W-1:0]            branch_target,
   input  logic                         jump_valid,
   input  logic [JIDX_W-1:0]            jump_index,
   input  logic                         link,
   input  logic                         return_valid,
   input  logic [ADDR_W-1:0]            jr_target,
   output logic [ADDR_W-1:0]            pc,
   output logic [ADDR_W-1:0]            pc_plus4,
   output logic                         redirect,
   output logic                         ras_mismatch,
   output logic [$clog2(RAS_DEPTH):0]   ras_count
);

   pc_src_e           src;
   logic [ADDR_W-1:0] next_pc;

   assign pc_plus4 = pc + 32'd4;

   // NOTE: src and next_pc get defaults first so no path leaves them
   // unassigned, which would otherwise infer latches.
   always_comb begin
      src     = SRC_SEQ;
      next_pc = pc_plus4;
      if (branch_valid) begin
         src     = SRC_BRANCH;
         next_pc = branch_target;
      end else if (jump_valid) begin
         src     = SRC_JUMP;
         next_pc = jump_target(pc_plus4, jump_index);
      end else if (return_valid) begin
         src     = SRC_RETURN;
         next_pc = jr_target;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc       <= RESET_PC;
         redirect <= 1'b0;
      end else if (!stall) begin
         pc       <= next_pc;
         redirect <= (src != SRC_SEQ);
      end
   end

`ifdef PC_SEQ_RAS_EN
   logic              ras_push;
   logic              ras_pop;
   logic              ras_empty;
   logic [ADDR_W-1:0] ras_top;

   // Only the winning request may touch the stack.
   assign ras_empty = (ras_count == '0);
   assign ras_push  = !stall && (src == SRC_JUMP) && link;
   assign ras_pop   = !stall && (src == SRC_RETURN) && !ras_empty;

   return_addr_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (ADDR_W)
   ) u_ras (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus4),
      .top       (ras_top),
      .count     (ras_count)
   );

   // The stack only predicts; jr_target always steers the PC.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ras_mismatch <= 1'b0;
      end else if (!stall) begin
         ras_mismatch <= (src == SRC_RETURN) && (ras_empty || (ras_top != jr_target));
      end
   end
`else
   logic unused_link;

   assign unused_link  = link;
   assign ras_mismatch = 1'b0;
   assign ras_count    = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of single-cycle vectors plus
// hand-written RAS overflow and asynchronous reset sequences.
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        jump_valid;
   logic [25:0] jump_index;
   logic        link;
   logic        return_valid;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic        ras_mismatch;
   logic [2:0]  ras_count;

   int n_cmp  = 0;
   int n_fail = 0;

   pc_sequencer #(
      .RESET_PC  (32'h0000_0000),
      .RAS_DEPTH (4)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .stall         (stall),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .jump_valid    (jump_valid),
      .jump_index    (jump_index),
      .link          (link),
      .return_valid  (return_valid),
      .jr_target     (jr_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .redirect      (redirect),
      .ras_mismatch  (ras_mismatch),
      .ras_count     (ras_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        st;
      logic        bv;
      logic [31:0] bt;
      logic        jv;
      logic [25:0] ji;
      logic        lk;
      logic        rv;
      logic [31:0] jt;
      logic [31:0] epc;
      logic        er;
      logic        em;
      int          ec;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   // RAS-dependent expectations collapse to 0 when the stack is not built.
   function automatic int c(input int n);
      return RAS_EN ? n : 0;
   endfunction

   function automatic logic m(input logic x);
      return RAS_EN ? x : 1'b0;
   endfunction

   function automatic vec_t vec(input logic st, input logic bv, input logic [31:0] bt,
                                input logic jv, input logic [25:0] ji, input logic lk,
                                input logic rv, input logic [31:0] jt,
                                input logic [31:0] epc, input logic er, input logic em,
                                input int ec);
      vec_t v;
      v.st = st; v.bv = bv; v.bt = bt; v.jv = jv; v.ji = ji; v.lk = lk;
      v.rv = rv; v.jt = jt; v.epc = epc; v.er = er; v.em = em; v.ec = ec;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
      jump_valid = 1'b0; jump_index = '0; link = 1'b0;
      return_valid = 1'b0; jr_target = '0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] epc, input logic er,
                            input logic em, input int ec);
      check({tag, " pc"}, pc, epc);
      check({tag, " pc_plus4"}, pc_plus4, epc + 32'd4);
      check({tag, " redirect"}, {31'd0, redirect}, {31'd0, er});
      check({tag, " ras_mismatch"}, {31'd0, ras_mismatch}, {31'd0, em});
      check({tag, " ras_count"}, {29'd0, ras_count}, 32'(ec));
   endtask

   logic [31:0] link_q [5];
   logic [31:0] exp_pc;

   initial begin
      //          st bv bt             jv ji        lk rv jt            epc            er em    ec
      vecs[0]  = vec(0, 0, 32'h0,        0, 26'h0,   0, 0, 32'h0,     32'h0000_0004, 0, 0,    0);
      vecs[1]  = vec(0, 0, 32'h0,        0, 26'h0,   0, 0, 32'h0,     32'h0000_0008, 0, 0,    0);
      vecs[2]  = vec(0, 0, 32'h0,        0, 26'h0,   0, 0, 32'h0,     32'h0000_000C, 0, 0,    0);
      vecs[3]  = vec(0, 1, 32'h1000_0040,0, 26'h0,   0, 0, 32'h0,     32'h1000_0040, 1, 0,    0);
      vecs[4]  = vec(0, 0, 32'h0,        1, 26'h100, 0, 0, 32'h0,     32'h1000_0400, 1, 0,    0);
      vecs[5]  = vec(0, 0, 32'h0,        0, 26'h0,   0, 0, 32'h0,     32'h1000_0404, 0, 0,    0);
      vecs[6]  = vec(0, 1, 32'h200,      1, 26'h3,   1, 1, 32'h123,   32'h0000_0200, 1, 0,    0);
      vecs[7]  = vec(0, 1, 32'h40,       0, 26'h0,   0, 0, 32'h0,     32'h0000_0040, 1, 0,    0);
      vecs[8]  = vec(0, 0, 32'h0,        1, 26'h100, 1, 0, 32'h0,     32'h0000_0400, 1, 0,    c(1));
      vecs[9]  = vec(0, 0, 32'h0,        0, 26'h0,   0, 1, 32'h44,    32'h0000_0044, 1, 0,    0);
      vecs[10] = vec(0, 0, 32'h0,        0, 26'h0,   0, 1, 32'h44,    32'h0000_0044, 1, m(1), 0);
      vecs[11] = vec(1, 0, 32'h0,        1, 26'h1,   1, 0, 32'h0,     32'h0000_0044, 1, m(1), 0);
      vecs[12] = vec(0, 0, 32'h0,        0, 26'h0,   0, 0, 32'h0,     32'h0000_0048, 0, 0,    0);
      vecs[13] = vec(0, 1, 32'h103,      0, 26'h0,   0, 0, 32'h0,     32'h0000_0103, 1, 0,    0);
      vecs[14] = vec(0, 0, 32'h0,        0, 26'h0,   0, 0, 32'h0,     32'h0000_0107, 0, 0,    0);
      vecs[15] = vec(0, 0, 32'h0,        1, 26'h80,  1, 0, 32'h0,     32'h0000_0200, 1, 0,    c(1));
      vecs[16] = vec(0, 0, 32'h0,        0, 26'h0,   0, 1, 32'h300,   32'h0000_0300, 1, m(1), 0);
      vecs[17] = vec(0, 0, 32'h0,        1, 26'h10,  1, 1, 32'h999,   32'h0000_0040, 1, 0,    c(1));
      vecs[18] = vec(0, 0, 32'h0,        0, 26'h0,   0, 1, 32'h304,   32'h0000_0304, 1, 0,    0);
      vecs[19] = vec(0, 1, 32'hEFFF_FFFC,0, 26'h0,   0, 0, 32'h0,     32'hEFFF_FFFC, 1, 0,    0);
      vecs[20] = vec(0, 0, 32'h0,        1, 26'h1,   0, 0, 32'h0,     32'hF000_0004, 1, 0,    0);
      vecs[21] = vec(0, 1, 32'hFFFF_FFFC,0, 26'h0,   0, 0, 32'h0,     32'hFFFF_FFFC, 1, 0,    0);
      vecs[22] = vec(0, 0, 32'h0,        0, 26'h0,   0, 0, 32'h0,     32'h0000_0000, 0, 0,    0);
      vecs[23] = vec(0, 0, 32'h0,        0, 26'h0,   0, 0, 32'h0,     32'h0000_0004, 0, 0,    0);

      idle_inputs();
      reset_n = 1'b0;
      step();
      step();
      check_all("reset", 32'h0, 1'b0, 1'b0, 0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         stall = vecs[i].st; branch_valid = vecs[i].bv; branch_target = vecs[i].bt;
         jump_valid = vecs[i].jv; jump_index = vecs[i].ji; link = vecs[i].lk;
         return_valid = vecs[i].rv; jr_target = vecs[i].jt;
         step();
         check_all($sformatf("row%0d", i), vecs[i].epc, vecs[i].er, vecs[i].em, vecs[i].ec);
      end

      // Five jal pushes into a 4-deep stack, then drain newest-first.
      idle_inputs();
      branch_valid = 1'b1; branch_target = 32'h1000;
      step();
      exp_pc = 32'h1000;
      check("ovf start pc", pc, exp_pc);
      for (int i = 0; i < 5; i++) begin
         idle_inputs();
         jump_valid = 1'b1; link = 1'b1;
         jump_index = 26'h400 + 26'((i + 1) * 'h40);
         link_q[i] = exp_pc + 32'd4;
         exp_pc = {link_q[i][31:28], jump_index, 2'b00};
         step();
         check($sformatf("jal%0d pc", i), pc, exp_pc);
         check($sformatf("jal%0d ras_count", i), {29'd0, ras_count}, 32'(c((i + 1 > 4) ? 4 : i + 1)));
      end
      for (int k = 0; k < 4; k++) begin
         idle_inputs();
         return_valid = 1'b1; jr_target = link_q[4 - k];
         step();
         check_all($sformatf("pop%0d", k), link_q[4 - k], 1'b1, 1'b0, c(3 - k));
      end
      idle_inputs();
      return_valid = 1'b1; jr_target = link_q[0];
      step();
      check_all("lost link", link_q[0], 1'b1, m(1), 0);

      // jal, then a stalled return, then an asynchronous reset mid-cycle.
      idle_inputs();
      jump_valid = 1'b1; link = 1'b1; jump_index = 26'h800;
      step();
      check_all("pre-stall jal", 32'h0000_2000, 1'b1, 1'b0, c(1));
      idle_inputs();
      stall = 1'b1; return_valid = 1'b1; jr_target = 32'h1008;
      step();
      check_all("stall ret", 32'h0000_2000, 1'b1, 1'b0, c(1));
      idle_inputs();
      #3;
      reset_n = 1'b0;
      #1;
      check_all("async rst", 32'h0, 1'b0, 1'b0, 0);
      step();
      check("rst held pc", pc, 32'h0);
      reset_n = 1'b1;
      step();
      check_all("post rst", 32'h4, 1'b0, 1'b0, 0);
      return_valid = 1'b1; jr_target = 32'h8;
      step();
      check_all("post rst pop", 32'h8, 1'b1, m(1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter owner for the single-cycle MIPS datapath: holds the architectural PC, consumes jump, branch and return redirect requests, and produces the next fetch address. It is the consumer end of the jump-target path. It forms the J-type target itself as {PC+4[31:28], target, 2'b00}, concatenated and not added. It also keeps a small return-address stack that records `jal` links and checks `jr $ra` targets.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC; ignore all requests this cycle
- branch_valid  in  1  taken branch this cycle
- branch_target  in  32  resolved branch address
- jump_valid  in  1  J-type jump (`j`/`jal`) this cycle
- jump_index  in  26  inst[25:0]
- link  in  1  jump is `jal`; qualified by jump_valid
- return_valid  in  1  `jr` this cycle
- jr_target  in  32  register value for `jr` (authoritative)
- pc  out  32  current fetch address
- pc_plus4  out  32  pc + 4 (combinational)
- redirect  out  1  pc was loaded from a non-sequential source on the last edge
- ras_mismatch  out  1  last accepted return disagreed with the RAS prediction
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

## Operation
- Next-PC priority: branch_valid > jump_valid > return_valid > pc_plus4. Only the winning request takes effect. Losing requests have no side effects, including no RAS push or pop.
- Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
- Return target is always jr_target. The RAS is a checker and predictor only, and never overrides jr_target.
- `jal` (jump wins, link=1): push pc_plus4.
- RAS full on push: overwrite the oldest entry. The top pointer wraps modulo RAS_DEPTH and ras_count saturates at RAS_DEPTH.
- Return wins, RAS non-empty: pop. ras_mismatch = (top ≠ jr_target).
- Return wins, RAS empty: no pop, ras_count stays 0, ras_mismatch = 1.
- stall=1 overrides everything: pc, RAS, redirect and ras_mismatch hold, and the cycle's requests are dropped. The requester must re-present them.
- pc_plus4 wraps 32'hFFFF_FFFC → 32'h0000_0000. No trap.
- Targets are not alignment-checked. The low two bits of branch_target and jr_target pass through.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) sets pc=RESET_PC, redirect=0, ras_mismatch=0, ras_count=0. RAS contents are don't-care. Reset mid-operation discards any pending request.
- Requests are sampled at the rising edge; pc reflects the target one cycle later. Latency is 1 clock and there is no bubble.
- redirect and ras_mismatch are registered, valid in the same cycle as the updated pc, and one cycle wide unless re-triggered.
- A push and a pop cannot occur in the same cycle, by priority.
- A pop immediately after a push returns the just-pushed value.

## Configuration
- PC_SEQ_RAS_EN defined: return-address stack built as above.
- Undefined: no stack storage. `jal` only redirects, returns still use jr_target, and ras_mismatch and ras_count are tied 0.

## Structure
- Shared package pc_pkg holds:
  - ADDR_W=32 and JIDX_W=26
  - the default RESET_PC
  - next-PC source enum {SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_RETURN}
- One sub-module, return_addr_stack (push, pop, top, count, circular pointer, overwrite-on-full), instantiated only under PC_SEQ_RAS_EN.

## Test plan
- Reset then 3 free-running cycles → pc 0x0, 0x4, 0x8, 0xC; redirect=0.
- pc=0x1000_0040, jump_valid with jump_index=0x0000100 → next pc=0x1000_0400, redirect=1 for one cycle.
- branch_valid (target 0x200) together with jump_valid and link=1 → pc=0x200, ras_count unchanged.
- At pc=0x40, `jal` to 0x400 → ras_count=1. Next, return_valid with jr_target=0x44 → pc=0x44, ras_mismatch=0, ras_count=0. Repeat the return → ras_mismatch=1, pc=jr_target.
- Five consecutive `jal` pushes with RAS_DEPTH=4 → ras_count=4. Four pops return the last four links newest-first, with the first link lost.
- stall=1 with jump_valid asserted → pc, ras_count and redirect unchanged. reset_n pulsed low mid-cycle → pc=RESET_PC immediately.
